// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings for the iterative multiply/divide unit
package mult_div_pkg;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    FINISH
  } state_t;

  // Booth pair {q[0], q[-1]}: 01 adds the multiplicand, 10 subtracts it
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - radix-2 Booth multiplier and restoring divider with HI/LO results
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;    // Booth accumulator, or partial remainder when dividing
  logic [WIDTH-1:0] qreg;   // multiplier, or dividend magnitude shifting into quotient
  logic [WIDTH-1:0] m;      // multiplicand, or divisor magnitude
  logic             q_1;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ok;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;

  assign m_ext = {m[WIDTH-1], m};

  always_comb begin
    booth_sum = acc;
    case ({qreg[0], q_1})
      BOOTH_ADD: booth_sum = acc + m_ext;
      BOOTH_SUB: booth_sum = acc - m_ext;
      default:   booth_sum = acc;
    endcase
  end

  assign booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign booth_q   = {booth_sum[0], qreg[WIDTH-1:1]};

  // Magnitude of most-negative still fits unsigned WIDTH bits, so overflow wraps naturally
  assign rem_shift = {acc[WIDTH-1:0], qreg[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, m};
  assign rem_ok    = ~rem_diff[WIDTH];
  assign rem_n     = rem_ok ? rem_diff : rem_shift;
  assign quo_n     = {qreg[WIDTH-2:0], rem_ok};
  assign quo_fix   = neg_q ? -quo_n : quo_n;
  assign rem_fix   = neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT)  state_next = MULT;
          else if (b == '0)   state_next = FINISH;
          else                state_next = DIV;
        end
      end
      MULT, DIV: if (cnt == '0) state_next = FINISH;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      cnt      <= '0;
      acc      <= '0;
      qreg     <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == FINISH);
      case (state)
        IDLE: begin
          if (start) begin
            div_zero <= (op == OP_DIV) && (b == '0);
            cnt      <= CNT_W'(WIDTH - 1);
            acc      <= '0;
            q_1      <= 1'b0;
            neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            neg_r    <= a[WIDTH-1];
            if (op == OP_MULT) begin
              m    <= a;
              qreg <= b;
            end else begin
              m    <= b_mag;
              qreg <= a_mag;
            end
          end
        end
        MULT: begin
          acc  <= booth_acc;
          qreg <= booth_q;
          q_1  <= qreg[0];
          if (cnt == '0) {hi, lo} <= {booth_acc[WIDTH-1:0], booth_q};
          else           cnt <= cnt - 1'b1;
        end
        DIV: begin
          acc  <= rem_n;
          qreg <= quo_n;
          if (cnt == '0) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start, op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  logic        start8, op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_hi32 = '0, last_lo32 = '0, last_hi8 = '0, last_lo8 = '0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] hi_of(input int w);
    return (w == 8) ? {24'b0, hi8} : hi;
  endfunction
  function automatic logic [31:0] lo_of(input int w);
    return (w == 8) ? {24'b0, lo8} : lo;
  endfunction
  function automatic logic busy_of(input int w);
    return (w == 8) ? busy8 : busy;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 8) ? done8 : done;
  endfunction
  function automatic logic dz_of(input int w);
    return (w == 8) ? div_zero8 : div_zero;
  endfunction

  task automatic drive(input int w, input logic s, input logic o,
                       input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      start8 = s; op8 = o; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start = s; op = o; a = av; b = bv;
    end
  endtask

  task automatic push_exp(input int w, input logic [31:0] eh, input logic [31:0] el, input logic dz);
    exp_t e;
    e.hi  = eh;
    e.lo  = el;
    e.dz  = dz;
    e.lat = dz ? 1 : w + 1;
    sb_q.push_back(e);
    if (w == 8) begin last_hi8 = eh; last_lo8 = el; end
    else begin last_hi32 = eh; last_lo32 = el; end
  endtask

  task automatic push_model(input int w, input logic o, input logic [31:0] av, input logic [31:0] bv);
    longint mask, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'({32'b0, av}) & mask;
    sb = longint'({32'b0, bv}) & mask;
    if (av[w-1]) sa -= (longint'(1) << w);
    if (bv[w-1]) sb -= (longint'(1) << w);
    if (o == 1'b0) begin
      p = sa * sb;
      push_exp(w, 32'((p >>> w) & mask), 32'(p & mask), 1'b0);
    end else if (sb == 0) begin
      push_exp(w, (w == 8) ? last_hi8 : last_hi32, (w == 8) ? last_lo8 : last_lo32, 1'b1);
    end else begin
      q = sa / sb;
      r = sa % sb;
      push_exp(w, 32'(r & mask), 32'(q & mask), 1'b0);
    end
  endtask

  task automatic run_op(input int w, input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input bit inject, input string tag);
    int          cyc, gcyc;
    bit          got;
    logic [31:0] ghi, glo;
    logic        gdz;
    exp_t        e;
    @(negedge clk);
    drive(w, 1'b1, o, av, bv);
    @(posedge clk);
    #1 drive(w, 1'b0, o, av, bv);
    cyc = 0; gcyc = 0; got = 0; ghi = '0; glo = '0; gdz = 1'b0;
    while (!got && cyc < w + 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy_c1"}, 64'(busy_of(w)), 64'd1);
      if (done_of(w)) begin
        got = 1; gcyc = cyc; ghi = hi_of(w); glo = lo_of(w); gdz = dz_of(w);
      end
      if (inject && (cyc == 5 || cyc == w + 1)) begin
        drive(w, 1'b1, 1'b1, $urandom, 32'd0);
        @(posedge clk);
        #1 drive(w, 1'b0, 1'b0, '0, '0);
      end
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    e = sb_q.pop_front();
    if (got) begin
      check({tag, "_latency"}, 64'(gcyc), 64'(e.lat));
      check({tag, "_hi"}, 64'(ghi), 64'(e.hi));
      check({tag, "_lo"}, 64'(glo), 64'(e.lo));
      check({tag, "_div_zero"}, 64'(gdz), 64'(e.dz));
    end
    @(negedge clk);
    check({tag, "_idle_after"}, 64'({busy_of(w), done_of(w)}), 64'd0);
  endtask

  task automatic dir_op(input int w, input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input logic dz, input string tag);
    push_exp(w, eh, el, dz);
    run_op(w, o, av, bv, 1'b0, tag);
  endtask

  task automatic rand_op(input int w, input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input bit inject, input string tag);
    push_model(w, o, av, bv);
    run_op(w, o, av, bv, inject, tag);
  endtask

  initial begin
    bit          seen;
    logic        ro;
    logic [31:0] ra, rb;

    reset = 1'b1;
    drive(32, 1'b0, 1'b0, '0, '0);
    drive(8, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state32", {busy, done, div_zero, hi, lo}, '0);
    check("reset_state8", {busy8, done8, div_zero8, hi8, lo8}, '0);
    reset = 1'b0;

    dir_op(32, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mul_7_m3");
    dir_op(32, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, "mul_minmin");
    dir_op(32, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, "mul_m1m1");
    dir_op(32, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2");
    dir_op(32, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, "div_7_m2");
    dir_op(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf");
    dir_op(32, 1'b1, 32'd1234, 32'd0, 32'h0, 32'h8000_0000, 1'b1, "div_zero");

    rand_op(32, 1'b0, 32'd12345, 32'hFFFF_FD5A, 1'b1, "mul_ignore_start");

    // abort a divide with reset in cycle 10
    @(negedge clk);
    drive(32, 1'b1, 1'b1, 32'd100000, 32'd7);
    @(posedge clk);
    #1 drive(32, 1'b0, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", {busy, done, div_zero, hi, lo}, '0);
    reset = 1'b0;
    last_hi32 = '0;
    last_lo32 = '0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = (i % 7 == 3) ? 32'h8000_0000 : $urandom;
      rb = (i % 5 == 4) ? 32'd0 : $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(1, 40)) ^ {32{ra[0]}};
      rand_op(32, ro, ra, rb, 1'b0, $sformatf("rand32_%0d", i));
    end

    dir_op(8, 1'b0, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0, "w8_mul_minmin");
    dir_op(8, 1'b1, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0, "w8_div_ovf");
    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : $urandom;
      rand_op(8, ro, ra, rb, 1'b0, $sformatf("rand8_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Parametrised iterative signed multiply/divide unit for the multicycle CPU datapath. It serves MULT and DIV instructions and produces results in HI/LO registers. The control unit launches an operation with a start pulse and stalls its FSM until done. It is WIDTH-generic so the same block serves the 32-bit core and narrower test configurations.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4.
CNT_W, $clog2(WIDTH), width of the internal iteration counter (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled only in IDLE
op  input  1  0 = signed multiply, 1 = signed divide
a  input  WIDTH  multiplicand / dividend (two's complement), sampled with start
b  input  WIDTH  multiplier / divisor (two's complement), sampled with start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; hi/lo/div_zero valid in that cycle and held afterwards
div_zero  output  1  set with done when a divide had b == 0; cleared on next accepted start
hi  output  WIDTH  mult: upper product half; div: remainder
lo  output  WIDTH  mult: lower product half; div: quotient

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0. Reset also aborts any operation in progress, with the same values on the next edge.
- FSM states: IDLE, MULT, DIV, FINISH.
- IDLE: on an edge with start=1, latch a, b and op, and clear div_zero.
  - op=0: go to MULT.
  - op=1 and b!=0: go to DIV.
  - op=1 and b==0: go directly to FINISH with div_zero pending.
- start is ignored in every other state. There is no queueing, and latched operands are unaffected.
- MULT: radix-2 Booth, one step per cycle for exactly WIDTH cycles.
  - The counter loads WIDTH-1 and decrements to 0, then the FSM moves to FINISH.
  - Accumulator is WIDTH+1 bits, with arithmetic right shift.
  - Result is the full signed 2*WIDTH-bit product.
- DIV: restoring division on operand magnitudes, WIDTH cycles, then FINISH.
  - Sign fix-up is applied on transition to FINISH.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow case a=most-negative, b=-1: quotient = most-negative (wraps), remainder = 0, div_zero=0.
- FINISH: lasts one cycle, with done=1 and busy=1.
  - hi/lo are registered on the edge entering FINISH.
  - div_zero=1 on that same edge if flagged; hi/lo keep their previous values in that case.
  - The next state is always IDLE.
- Latency, with the start edge at cycle 0:
  - done is high in cycle WIDTH+1 for mult/div (33 for WIDTH=32).
  - done is high in cycle 1 for divide-by-zero.
  - A new start is accepted in the cycle after done, giving back-to-back throughput of WIDTH+2 cycles.
- hi/lo change only on the edge entering FINISH (or on reset); outside that edge they hold.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package mult_div_pkg holds:
  - op encoding: OP_MULT=1'b0, OP_DIV=1'b1;
  - FSM state enum: IDLE, MULT, DIV, FINISH;
  - the Booth pair-decode constants.
- Sub-module: none required. The Booth step and restoring-subtract step are each a few lines inside the single always block; keeping them in one module eases state/counter verification.

Test Plan:
- WIDTH=32, op=0, a=7, b=-3 (0xFFFFFFFD) -> done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
- op=0, a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000; then op=0, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
- op=1, a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then a=7, b=-2 -> lo=0xFFFFFFFD, hi=1; div_zero=0 in both.
- op=1, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. op=1, b=0 -> done at cycle 1, div_zero=1, hi/lo unchanged from the prior result.
- Pulse start with new operands at cycles 5 and 33 during a mult -> ignored, result equals the original operands. Assert reset at cycle 10 of a divide -> next cycle busy=0, hi=lo=0, done never pulses.
- WIDTH=8 instance, a=-128, b=-128, op=0 -> done at cycle 9, {hi,lo}=0x4000. Random signed operands are compared against a reference model.
